// File: rtl/demux_scan_sched.sv
// Channel sequencer for a 32-channel analog demux: round-robin scan plus priority host requests.
// Define DEMUX_SCHED_BBM_EN for break-before-make (ena low while a channel is being reprogrammed).
module demux_scan_sched #(
    parameter logic [23:0] DWELL_CYCLES    = 24'd2000000,
    parameter logic [7:0]  SETUP_CYCLES    = 8'd4,
    parameter logic [7:0]  WR_PULSE_CYCLES = 8'd4,
    parameter logic [7:0]  HOLD_CYCLES     = 8'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [31:0] scan_mask,
    input  logic        req_valid,
    input  logic [4:0]  req_ch,
    output logic        req_ready,
    output logic        ena,
    output logic        wr,
    output logic        cs,
    output logic [4:0]  set_ch,
    output logic        ch_valid,
    output logic        busy
);
    localparam int unsigned CNT_W = 24;
    localparam int unsigned CH_W  = 5;
    localparam int unsigned NCH   = 32;

    // Reload values are cycles-1; a zero parameter behaves as a single cycle.
    localparam logic [CNT_W-1:0] LD_DWELL = (DWELL_CYCLES == 24'd0) ? 24'd0 : DWELL_CYCLES - 24'd1;
    localparam logic [CNT_W-1:0] LD_SETUP = (SETUP_CYCLES == 8'd0) ? 24'd0 : CNT_W'(SETUP_CYCLES) - 24'd1;
    localparam logic [CNT_W-1:0] LD_WR    = (WR_PULSE_CYCLES == 8'd0) ? 24'd0 : CNT_W'(WR_PULSE_CYCLES) - 24'd1;
    localparam logic [CNT_W-1:0] LD_HOLD  = (HOLD_CYCLES == 8'd0) ? 24'd0 : CNT_W'(HOLD_CYCLES) - 24'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_WRITE = 3'd2,
        S_HOLD  = 3'd3,
        S_DWELL = 3'd4
    } state_t;

    state_t            r_state,     w_state_n;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_n;
    logic [CH_W-1:0]   r_scan_ptr,  w_scan_ptr_n;
    logic [CH_W-1:0]   r_set_ch,    w_set_ch_n;
    logic              r_req_ready, w_req_ready_n;
    logic              r_ena,       w_ena_n;
    logic              r_wr,        w_wr_n;
    logic              r_cs,        w_cs_n;
    logic              r_ch_valid,  w_ch_valid_n;
    logic              r_busy;

    logic [CH_W-1:0]   w_scan_ch;
    logic [CH_W-1:0]   w_sel_ch;
    logic              w_last;
    logic              w_req_fire;
    logic              w_scan_hit;
    logic              w_sel_go;
    logic              w_enter_setup;
    logic              w_to_idle;

    assign w_last     = (r_cnt == '0);
    assign w_req_fire = req_valid & r_req_ready;
    assign w_scan_hit = scan_en & (|scan_mask);
    assign w_sel_go   = w_req_fire | w_scan_hit;
    assign w_sel_ch   = w_req_fire ? req_ch : w_scan_ch;

    // First set mask bit at or after scan_ptr+1 (mod 32); k=31 lands back on scan_ptr itself.
    always_comb begin
        logic [CH_W-1:0] v_idx;
        w_scan_ch = r_scan_ptr;
        v_idx     = r_scan_ptr;
        for (int k = NCH - 1; k >= 0; k--) begin
            v_idx = r_scan_ptr + CH_W'(k + 1);
            if (scan_mask[v_idx]) begin
                w_scan_ch = v_idx;
            end
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_scan_ptr_n  = r_scan_ptr;
        w_set_ch_n    = r_set_ch;
        w_req_ready_n = r_req_ready;
        w_ena_n       = r_ena;
        w_wr_n        = r_wr;
        w_cs_n        = r_cs;
        w_ch_valid_n  = r_ch_valid;
        w_enter_setup = 1'b0;
        w_to_idle     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_sel_go) w_enter_setup = 1'b1;
                else          w_to_idle     = 1'b1;
            end
            S_SETUP: begin
                if (w_last) begin
                    w_state_n = S_WRITE;
                    w_cnt_n   = LD_WR;
                    w_wr_n    = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 24'd1;
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    w_state_n = S_HOLD;
                    w_cnt_n   = LD_HOLD;
                    w_wr_n    = 1'b0;
                end else begin
                    w_cnt_n = r_cnt - 24'd1;
                end
            end
            S_HOLD: begin
                if (w_last) begin
                    w_state_n     = S_DWELL;
                    w_cnt_n       = LD_DWELL;
                    w_cs_n        = 1'b0;
                    w_ena_n       = 1'b1;
                    w_ch_valid_n  = 1'b1;
                    w_req_ready_n = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 24'd1;
                end
            end
            S_DWELL: begin
                // An accepted request cuts the dwell short.
                if (w_req_fire || w_last) begin
                    if (w_sel_go) w_enter_setup = 1'b1;
                    else          w_to_idle     = 1'b1;
                end else begin
                    w_cnt_n = r_cnt - 24'd1;
                end
            end
            default: w_to_idle = 1'b1;
        endcase

        if (w_enter_setup) begin
            w_state_n     = S_SETUP;
            w_cnt_n       = LD_SETUP;
            w_set_ch_n    = w_sel_ch;
            w_cs_n        = 1'b1;
            w_wr_n        = 1'b0;
            w_ch_valid_n  = 1'b0;
            w_req_ready_n = 1'b0;
            if (!w_req_fire) w_scan_ptr_n = w_scan_ch;
`ifdef DEMUX_SCHED_BBM_EN
            w_ena_n       = 1'b0;
`else
            w_ena_n       = r_ena;
`endif
        end

        if (w_to_idle) begin
            w_state_n     = S_IDLE;
            w_cnt_n       = '0;
            w_cs_n        = 1'b0;
            w_wr_n        = 1'b0;
            w_ena_n       = 1'b0;
            w_ch_valid_n  = 1'b0;
            w_req_ready_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_scan_ptr  <= 5'd31;
            r_set_ch    <= '0;
            r_req_ready <= 1'b0;
            r_ena       <= 1'b0;
            r_wr        <= 1'b0;
            r_cs        <= 1'b0;
            r_ch_valid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_scan_ptr  <= w_scan_ptr_n;
            r_set_ch    <= w_set_ch_n;
            r_req_ready <= w_req_ready_n;
            r_ena       <= w_ena_n;
            r_wr        <= w_wr_n;
            r_cs        <= w_cs_n;
            r_ch_valid  <= w_ch_valid_n;
            r_busy      <= (w_state_n != S_IDLE);
        end
    end

    assign req_ready = r_req_ready;
    assign ena       = r_ena;
    assign wr        = r_wr;
    assign cs        = r_cs;
    assign set_ch    = r_set_ch;
    assign ch_valid  = r_ch_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_demux_scan_sched.sv
// Scoreboard bench for demux_scan_sched: stimulus queues expected channels, a monitor checks each dwell.
module tb_demux_scan_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scan_en = 1'b0;
    logic [31:0] scan_mask = '0;
    logic        req_valid = 1'b0;
    logic [4:0]  req_ch = '0;
    logic        req_ready, ena, wr, cs, ch_valid, busy;
    logic [4:0]  set_ch;

    demux_scan_sched #(
        .DWELL_CYCLES    (24'd8),
        .SETUP_CYCLES    (8'd2),
        .WR_PULSE_CYCLES (8'd2),
        .HOLD_CYCLES     (8'd1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .scan_mask (scan_mask),
        .req_valid (req_valid),
        .req_ch    (req_ch),
        .req_ready (req_ready),
        .ena       (ena),
        .wr        (wr),
        .cs        (cs),
        .set_ch    (set_ch),
        .ch_valid  (ch_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] ch;
        int         len;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef DEMUX_SCHED_BBM_EN
    localparam logic EXP_ENA_RP = 1'b0;
`else
    localparam logic EXP_ENA_RP = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ch(input logic [4:0] ch, input int len);
        exp_t e;
        e.ch  = ch;
        e.len = len;
        sb_q.push_back(e);
    endtask

    task automatic wait_dwell(input logic [4:0] ch, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(ch_valid && set_ch == ch) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(ch_valid && set_ch == ch), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Monitor: every ch_valid rise pops one expected channel; programming shape and dwell length are checked too.
    initial begin : monitor
        logic prev_v;
        int   cs_cnt, wr_start, wr_cnt, v_cnt;
        exp_t cur;
        prev_v = 1'b0; cs_cnt = 0; wr_start = 0; wr_cnt = 0; v_cnt = 0;
        cur.ch = '0; cur.len = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_v = 1'b0; cs_cnt = 0; wr_start = 0; wr_cnt = 0; v_cnt = 0;
            end else begin
                if (cs) begin
                    cs_cnt++;
                    if (wr) begin
                        if (wr_cnt == 0) wr_start = cs_cnt;
                        wr_cnt++;
                    end
                end
                if (ch_valid && !prev_v) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_unexpected: channel %0d presented with none expected at t=%0t", set_ch, $time);
                    end else begin
                        cur = sb_q.pop_front();
                        check("sb_ch", 32'(set_ch), 32'(cur.ch));
                        check("cs_width", cs_cnt, 32'd5);
                        check("wr_start", wr_start, 32'd3);
                        check("wr_width", wr_cnt, 32'd2);
                        check("cs_low_dwell", 32'(cs), 32'd0);
                        check("ena_dwell", 32'(ena), 32'd1);
                    end
                    cs_cnt = 0; wr_start = 0; wr_cnt = 0; v_cnt = 0;
                end
                if (ch_valid) v_cnt++;
                if (!ch_valid && prev_v) check("dwell_len", v_cnt, 32'(cur.len));
                prev_v = ch_valid;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs", 32'({req_ready, ena, wr, cs, set_ch, ch_valid, busy}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ena", 32'(ena), 32'd0);

        // Scan 0,2,8 with a request for 17 preempting the dwell on 2.
        expect_ch(5'd0, 8); expect_ch(5'd2, 3); expect_ch(5'd17, 8);
        expect_ch(5'd8, 8); expect_ch(5'd0, 8);
        scan_mask = 32'h0000_0105;
        scan_en   = 1'b1;
        @(negedge clk);
        check("first_prog_cs", 32'(cs), 32'd1);
        check("first_prog_ena", 32'(ena), 32'd0);
        check("first_set_ch", 32'(set_ch), 32'd0);
        wait_dwell(5'd2, "reach_ch2");
        repeat (2) @(negedge clk);
        check("preempt_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_ch    = 5'd17;
        @(negedge clk);
        req_valid = 1'b0;
        check("preempt_drop", 32'(ch_valid), 32'd0);
        check("preempt_set_ch", 32'(set_ch), 32'd17);
        check("reprog_ena", 32'(ena), 32'(EXP_ENA_RP));
        wait_dwell(5'd8, "resume_ch8");
        wait_dwell(5'd0, "wrap_ch0");
        scan_en = 1'b0;
        wait_idle("scan_stop");
        check("stop_ena", 32'(ena), 32'd0);
        check("stop_ready", 32'(req_ready), 32'd1);
        check("stop_set_ch_hold", 32'(set_ch), 32'd0);

        // Request 9 from IDLE; request 5 raised during SETUP waits for the DWELL of 9.
        expect_ch(5'd9, 1); expect_ch(5'd5, 8);
        req_valid = 1'b1;
        req_ch    = 5'd9;
        @(negedge clk);
        req_ch = 5'd5;
        check("blk_set_ch9", 32'(set_ch), 32'd9);
        n = 0;
        while (!ch_valid && n < 20) begin
            check("blk_not_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        check("blk_ready_dwell", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("blk_abort", 32'(ch_valid), 32'd0);
        check("blk_set_ch5", 32'(set_ch), 32'd5);
        wait_idle("blk_done");

        // Empty mask keeps the sequencer idle.
        scan_mask = 32'h0;
        scan_en   = 1'b1;
        repeat (10) @(negedge clk);
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_ena", 32'(ena), 32'd0);
        check("empty_cs", 32'(cs), 32'd0);

        // Pointer is still 0 (requests leave it alone): next is 31, then wrap to 0.
        expect_ch(5'd31, 8); expect_ch(5'd0, 8);
        scan_mask = 32'h8000_0001;
        wait_dwell(5'd31, "wrap_31");
        wait_dwell(5'd0, "wrap_0");
        scan_en = 1'b0;
        wait_idle("wrap_done");

        // Single-bit mask rewrites the same channel.
        expect_ch(5'd4, 8); expect_ch(5'd4, 8);
        scan_mask = 32'h0000_0010;
        scan_en   = 1'b1;
        wait_dwell(5'd4, "single_a");
        n = 0;
        while (ch_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        wait_dwell(5'd4, "single_b");
        scan_en = 1'b0;
        wait_idle("single_done");

        // Async reset in the middle of the write pulse for channel 0 (after 8).
        expect_ch(5'd8, 8);
        scan_mask = 32'h0000_0105;
        scan_en   = 1'b1;
        wait_dwell(5'd8, "rst_pre_ch8");
        n = 0;
        while (!wr && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_in_write", 32'(wr), 32'd1);
        check("rst_write_ena", 32'(ena), 32'(EXP_ENA_RP));
        check("rst_write_ch", 32'(set_ch), 32'd0);
        #2 rst = 1'b0;
        #1;
        check("rst_async_outs", 32'({wr, cs, ena, ch_valid, busy, req_ready}), 32'd0);
        repeat (2) @(negedge clk);
        scan_en = 1'b0;
        rst     = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_quiet", 32'({wr, cs, busy, ch_valid}), 32'd0);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
